button_match_round: RTL and testbench

Parametrised round controller for the button-match minigame. It draws a pseudo-random target from a free-running LFSR and arms a countdown timer. It then judges the player's button press as a hit, miss or timeout, keeps a saturating score, and ends the game after a set number of rounds. It sits between the debounced/inverted KEY inputs and the HEX/LEDR display logic.

---
 rtl/button_match_round.sv | 167 ++++++++++++++++
 tb/tb_button_match_round.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/button_match_round.sv
// Round controller for the button-match minigame: LFSR target draw, response timer, hit/miss judging, score.
// Define BMR_SPEEDUP_EN to shrink the response window by 1/8 after every hit (floored at MIN_TIMEOUT).
module button_match_round #(
    parameter int          NUM_BUTTONS    = 4,
    parameter int          TIMEOUT_CYCLES = 50_000_000,
    parameter int          MIN_TIMEOUT    = 5_000_000,
    parameter int          ROUNDS         = 10,
    parameter int          SCORE_W        = 8,
    parameter logic [15:0] SEED           = 16'h1C7F
) (
    input  logic                           clock,
    input  logic                           resetn,
    input  logic                           start,
    input  logic [NUM_BUTTONS-1:0]         buttons,
    output logic [$clog2(NUM_BUTTONS)-1:0] target,
    output logic                           target_valid,
    output logic                           hit,
    output logic                           miss,
    output logic                           timed_out,
    output logic [SCORE_W-1:0]             score,
    output logic [7:0]                     round_cnt,
    output logic                           game_over
);

    localparam int          TW       = $clog2(NUM_BUTTONS);
    localparam int          CW       = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] WIN_INIT = CW'(TIMEOUT_CYCLES);
    localparam logic [CW-1:0] MIN_C    = CW'(MIN_TIMEOUT);
    localparam logic [15:0] SEED_EFF = (SEED == 16'h0000) ? 16'h0001 : SEED;
    localparam logic [7:0]  ROUNDS_C = 8'(ROUNDS);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARM,
        S_WAIT,
        S_HIT,
        S_MISS,
        S_DONE
    } state_t;

    state_t                 state;
    logic [15:0]            lfsr;
    logic [NUM_BUTTONS-1:0] buttons_q;
    logic [NUM_BUTTONS-1:0] press_p1;
    logic                   has_prev;
    logic [CW-1:0]          window;
    logic [CW-1:0]          timer;
    logic [TW-1:0]          next_tgt;
    logic [NUM_BUTTONS-1:0] tgt_onehot;

    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        return v[0] ? ((v >> 1) ^ 16'hB400) : (v >> 1);
    endfunction

    function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] v);
        return (&v) ? v : v + SCORE_W'(1);
    endfunction

    function automatic logic [CW-1:0] shrink_window(input logic [CW-1:0] w);
        logic [CW-1:0] n;
        n = w - (w >> 3);
        return (n < MIN_C) ? MIN_C : n;
    endfunction

    // A draw equal to the previous target is bumped by one so rounds never repeat a button.
    function automatic logic [TW-1:0] pick_target(input logic [TW-1:0] raw,
                                                  input logic [TW-1:0] prev,
                                                  input logic          valid_prev);
        return (valid_prev && raw == prev) ? raw + TW'(1) : raw;
    endfunction

    always_comb begin
        next_tgt   = pick_target(lfsr[TW-1:0], target, has_prev);
        tgt_onehot = NUM_BUTTONS'(1) << target;
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state        <= S_IDLE;
            lfsr         <= SEED_EFF;
            buttons_q    <= '0;
            press_p1     <= '0;
            has_prev     <= 1'b0;
            window       <= WIN_INIT;
            timer        <= '0;
            target       <= '0;
            target_valid <= 1'b0;
            hit          <= 1'b0;
            miss         <= 1'b0;
            timed_out    <= 1'b0;
            score        <= '0;
            round_cnt    <= '0;
            game_over    <= 1'b0;
        end else begin
            lfsr      <= lfsr_step(lfsr);
            buttons_q <= buttons;
            // stage p1: rising edges registered one cycle after the button changes
            press_p1  <= buttons & ~buttons_q;
            hit       <= 1'b0;
            miss      <= 1'b0;
            timed_out <= 1'b0;
            case (state)
                S_IDLE: begin
                    score     <= '0;
                    round_cnt <= '0;
                    window    <= WIN_INIT;
                    if (start) state <= S_ARM;
                end
                S_ARM: begin
                    if (buttons == '0) begin
                        target       <= next_tgt;
                        has_prev     <= 1'b1;
                        timer        <= window - CW'(1);
                        target_valid <= 1'b1;
                        state        <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (press_p1 != '0) begin
                        target_valid <= 1'b0;
                        round_cnt    <= round_cnt + 8'd1;
                        if (press_p1 == tgt_onehot) begin
                            state <= S_HIT;
                            hit   <= 1'b1;
                            score <= sat_inc(score);
`ifdef BMR_SPEEDUP_EN
                            window <= shrink_window(window);
`else
                            window <= window;
`endif
                        end else begin
                            state <= S_MISS;
                            miss  <= 1'b1;
                        end
                    end else if (timer == '0) begin
                        target_valid <= 1'b0;
                        round_cnt    <= round_cnt + 8'd1;
                        state        <= S_MISS;
                        miss         <= 1'b1;
                        timed_out    <= 1'b1;
                    end else begin
                        timer <= timer - CW'(1);
                    end
                end
                S_HIT, S_MISS: begin
                    if (round_cnt == ROUNDS_C) begin
                        state     <= S_DONE;
                        game_over <= 1'b1;
                    end else begin
                        state <= S_ARM;
                    end
                end
                S_DONE: begin
                    if (start) begin
                        state     <= S_ARM;
                        game_over <= 1'b0;
                        score     <= '0;
                        round_cnt <= '0;
                        window    <= WIN_INIT;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_button_match_round.sv
// Directed bench for button_match_round with NUM_BUTTONS=4, TIMEOUT_CYCLES=20, MIN_TIMEOUT=12, ROUNDS=3.
// Window expectations follow BMR_SPEEDUP_EN when it is defined.
module tb_button_match_round;

    localparam int TO = 20;
`ifdef BMR_SPEEDUP_EN
    localparam bit SPEEDUP = 1'b1;
`else
    localparam bit SPEEDUP = 1'b0;
`endif

    logic       clock   = 1'b0;
    logic       resetn  = 1'b0;
    logic       start   = 1'b0;
    logic [3:0] buttons = 4'b0000;
    logic [1:0] target;
    logic       target_valid, hit, miss, timed_out, game_over;
    logic [7:0] score, round_cnt;

    int checks = 0;
    int errors = 0;

    logic [15:0] m_lfsr, m_lfsr_q;
    logic        have_prev = 1'b0;
    logic [1:0]  prev_tgt  = 2'd0;

    button_match_round #(
        .NUM_BUTTONS(4), .TIMEOUT_CYCLES(TO), .MIN_TIMEOUT(12),
        .ROUNDS(3), .SCORE_W(8), .SEED(16'h1C7F)
    ) dut (
        .clock(clock), .resetn(resetn), .start(start), .buttons(buttons),
        .target(target), .target_valid(target_valid), .hit(hit), .miss(miss),
        .timed_out(timed_out), .score(score), .round_cnt(round_cnt), .game_over(game_over)
    );

    always #5 clock = ~clock;

    // Reference Galois LFSR; m_lfsr_q is the value the DUT saw before the latest edge
    always @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            m_lfsr   <= 16'h1C7F;
            m_lfsr_q <= 16'h1C7F;
        end else begin
            m_lfsr_q <= m_lfsr;
            m_lfsr   <= m_lfsr[0] ? ((m_lfsr >> 1) ^ 16'hB400) : (m_lfsr >> 1);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic wait_valid(output int n);
        logic [1:0] exp_t;
        n = 0;
        while (target_valid !== 1'b1 && n < 60) begin
            @(negedge clock);
            n++;
        end
        checks++;
        if (target_valid !== 1'b1) begin
            errors++;
            $display("FAIL wait_valid: target_valid=%b after %0d cycles, required 1", target_valid, n);
        end else begin
            exp_t = m_lfsr_q[1:0];
            if (have_prev && exp_t == prev_tgt) exp_t = exp_t + 2'd1;
            checks++;
            if (target !== exp_t) begin
                errors++;
                $display("FAIL target_draw: got %0d, required %0d", target, exp_t);
            end
            if (have_prev) begin
                checks++;
                if (target === prev_tgt) begin
                    errors++;
                    $display("FAIL target_repeat: got %0d, required != %0d", target, prev_tgt);
                end
            end
            prev_tgt  = target;
            have_prev = 1'b1;
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
    endtask

    task automatic play_hit(input logic [7:0] exp_score, input logic [7:0] exp_rc);
        int n;
        wait_valid(n);
        buttons = 4'b0001 << target;
        @(negedge clock);
        checks++;
        if (hit !== 1'b0) begin errors++; $display("FAIL hit_early: hit=%b, required 0", hit); end
        @(negedge clock);
        checks++;
        if (hit !== 1'b1 || miss !== 1'b0) begin
            errors++; $display("FAIL hit_pulse: hit=%b miss=%b, required 1 0", hit, miss);
        end
        checks++;
        if (score !== exp_score) begin errors++; $display("FAIL hit_score: got %0d, required %0d", score, exp_score); end
        checks++;
        if (round_cnt !== exp_rc) begin errors++; $display("FAIL hit_round: got %0d, required %0d", round_cnt, exp_rc); end
        buttons = 4'b0000;
        @(negedge clock);
        checks++;
        if (hit !== 1'b0) begin errors++; $display("FAIL hit_width: hit=%b, required 0", hit); end
    endtask

    task automatic play_miss(input bit multi, input logic [7:0] exp_score, input logic [7:0] exp_rc);
        int n;
        logic [1:0] other;
        wait_valid(n);
        other   = target + 2'd1;
        buttons = multi ? ((4'b0001 << target) | (4'b0001 << other)) : (4'b0001 << other);
        @(negedge clock);
        checks++;
        if (miss !== 1'b0) begin errors++; $display("FAIL miss_early: miss=%b, required 0", miss); end
        @(negedge clock);
        checks++;
        if (miss !== 1'b1 || timed_out !== 1'b0 || hit !== 1'b0) begin
            errors++; $display("FAIL miss_pulse: miss=%b timed_out=%b hit=%b, required 1 0 0", miss, timed_out, hit);
        end
        checks++;
        if (score !== exp_score) begin errors++; $display("FAIL miss_score: got %0d, required %0d", score, exp_score); end
        checks++;
        if (round_cnt !== exp_rc) begin errors++; $display("FAIL miss_round: got %0d, required %0d", round_cnt, exp_rc); end
        buttons = 4'b0000;
        @(negedge clock);
        checks++;
        if (miss !== 1'b0) begin errors++; $display("FAIL miss_width: miss=%b, required 0", miss); end
    endtask

    task automatic play_timeout(input int exp_win, input logic [7:0] exp_rc, output int lat);
        int k;
        wait_valid(lat);
        k = 0;
        while (miss !== 1'b1 && k < 100) begin
            @(negedge clock);
            k++;
        end
        checks++;
        if (k != exp_win) begin errors++; $display("FAIL timeout_window: got %0d cycles, required %0d", k, exp_win); end
        checks++;
        if (timed_out !== 1'b1 || hit !== 1'b0) begin
            errors++; $display("FAIL timeout_flag: timed_out=%b hit=%b, required 1 0", timed_out, hit);
        end
        checks++;
        if (round_cnt !== exp_rc) begin errors++; $display("FAIL timeout_round: got %0d, required %0d", round_cnt, exp_rc); end
        @(negedge clock);
    endtask

    task automatic play_late_hit(input int win, input logic [7:0] exp_score, input logic [7:0] exp_rc);
        int n;
        wait_valid(n);
        repeat (win - 2) @(negedge clock);
        buttons = 4'b0001 << target;
        @(negedge clock);
        checks++;
        if (target_valid !== 1'b1 || hit !== 1'b0) begin
            errors++; $display("FAIL late_window: target_valid=%b hit=%b, required 1 0", target_valid, hit);
        end
        @(negedge clock);
        checks++;
        if (hit !== 1'b1 || miss !== 1'b0 || timed_out !== 1'b0) begin
            errors++; $display("FAIL late_hit: hit=%b miss=%b timed_out=%b, required 1 0 0", hit, miss, timed_out);
        end
        checks++;
        if (score !== exp_score || round_cnt !== exp_rc) begin
            errors++; $display("FAIL late_count: score=%0d round=%0d, required %0d %0d", score, round_cnt, exp_score, exp_rc);
        end
        buttons = 4'b0000;
        @(negedge clock);
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        repeat (2) @(negedge clock);
        checks++;
        if ({target, target_valid, hit, miss, timed_out, game_over} !== 7'd0) begin
            errors++;
            $display("FAIL reset_flags: target=%0d valid=%b hit=%b miss=%b to=%b over=%b, required all 0",
                     target, target_valid, hit, miss, timed_out, game_over);
        end
        checks++;
        if (score !== 8'd0 || round_cnt !== 8'd0) begin
            errors++; $display("FAIL reset_counts: score=%0d round=%0d, required 0 0", score, round_cnt);
        end
        resetn = 1'b1;
        repeat (3) @(negedge clock);
        checks++;
        if (target_valid !== 1'b0 || game_over !== 1'b0) begin
            errors++; $display("FAIL idle_hold: valid=%b over=%b, required 0 0", target_valid, game_over);
        end
    endtask

    task automatic test_correct_press();
        pulse_start();
        play_hit(8'd1, 8'd1);
    endtask

    task automatic test_wrong_and_multi();
        play_miss(1'b0, 8'd1, 8'd2);
        play_miss(1'b1, 8'd1, 8'd3);
    endtask

    task automatic test_game_end();
        checks++;
        if (game_over !== 1'b1 || round_cnt !== 8'd3 || score !== 8'd1 || target_valid !== 1'b0) begin
            errors++;
            $display("FAIL done_state: over=%b round=%0d score=%0d valid=%b, required 1 3 1 0",
                     game_over, round_cnt, score, target_valid);
        end
        repeat (4) @(negedge clock);
        checks++;
        if (game_over !== 1'b1 || round_cnt !== 8'd3 || score !== 8'd1) begin
            errors++; $display("FAIL done_hold: over=%b round=%0d score=%0d, required 1 3 1", game_over, round_cnt, score);
        end
    endtask

    task automatic test_restart();
        int lat;
        buttons = 4'b0010;
        pulse_start();
        checks++;
        if (game_over !== 1'b0 || score !== 8'd0 || round_cnt !== 8'd0) begin
            errors++; $display("FAIL restart_clear: over=%b score=%0d round=%0d, required 0 0 0", game_over, score, round_cnt);
        end
        repeat (4) @(negedge clock);
        checks++;
        if (target_valid !== 1'b0) begin errors++; $display("FAIL arm_blocked: valid=%b, required 0", target_valid); end
        buttons = 4'b0000;
        play_timeout(TO, 8'd1, lat);
        checks++;
        if (lat != 1) begin errors++; $display("FAIL arm_release: got %0d cycles, required 1", lat); end
        play_late_hit(TO, 8'd1, 8'd2);
        play_timeout(SPEEDUP ? 18 : TO, 8'd3, lat);
    endtask

    task automatic test_speedup();
        int lat;
        pulse_start();
        play_hit(8'd1, 8'd1);
        play_hit(8'd2, 8'd2);
        play_timeout(SPEEDUP ? 16 : TO, 8'd3, lat);
        checks++;
        if (game_over !== 1'b1 || score !== 8'd2) begin
            errors++; $display("FAIL speedup_done: over=%b score=%0d, required 1 2", game_over, score);
        end
    endtask

    task automatic test_reset_mid_wait();
        int n;
        pulse_start();
        play_hit(8'd1, 8'd1);
        wait_valid(n);
        repeat (3) @(negedge clock);
        resetn = 1'b0;
        #1;
        checks++;
        if ({target, target_valid, hit, miss, timed_out, game_over} !== 7'd0) begin
            errors++;
            $display("FAIL async_reset_flags: target=%0d valid=%b hit=%b miss=%b to=%b over=%b, required all 0",
                     target, target_valid, hit, miss, timed_out, game_over);
        end
        checks++;
        if (score !== 8'd0 || round_cnt !== 8'd0) begin
            errors++; $display("FAIL async_reset_counts: score=%0d round=%0d, required 0 0", score, round_cnt);
        end
        @(negedge clock);
        resetn    = 1'b1;
        have_prev = 1'b0;
        repeat (3) @(negedge clock);
        checks++;
        if (target_valid !== 1'b0 || game_over !== 1'b0) begin
            errors++; $display("FAIL post_reset_idle: valid=%b over=%b, required 0 0", target_valid, game_over);
        end
        pulse_start();
        wait_valid(n);
        checks++;
        if (n != 1) begin errors++; $display("FAIL start_latency: got %0d cycles, required 1", n); end
    endtask

    initial begin
        test_reset();
        test_correct_press();
        test_wrong_and_multi();
        test_game_end();
        test_restart();
        test_speedup();
        test_reset_mid_wait();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
